// File: rtl/bus_arbiter_2m.sv
// -----------------------------------------------------------------------------
// bus_arbiter_2m
//
// Two-master bus arbiter with split-transaction parking. A master that is told
// by the slave to split is parked: its grant drops, the other master may use
// the bus meanwhile, and the parked master is resumed ahead of any new request
// once split falls and the bus is free. Only one park can be outstanding.
//
// Parameters
//   ARB_MODE      0 = fixed priority (master 0 wins), 1 = round-robin
//
// Ports
//   clk           system clock, all state updates on its rising edge
//   rstn          asynchronous active-low reset
//   breq[1:0]     per-master bus request
//   split         slave has parked a read (level)
//   grant[1:0]    registered per-master grant, one-hot or zero
//   msel          registered index of the routed master, holds when idle
//   busy          registered, high whenever a grant bit is high
//   split_owner   registered index of the parked master (valid with pending)
//   split_pending registered, high while a master is parked
// -----------------------------------------------------------------------------
module bus_arbiter_2m #(
  parameter int ARB_MODE = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] breq,
  input  logic       split,
  output logic [1:0] grant,
  output logic       msel,
  output logic       busy,
  output logic       split_owner,
  output logic       split_pending
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    BUSY        = 2'd1,
    PARKED_IDLE = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;

  logic [1:0] elig;
  logic [1:0] pick_r;
  logic       resume;
  logic       park_cancel;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Result is {found, index}. With both masters eligible, round-robin favours
  // the one that did not hold the bus last.
  function automatic logic [1:0] pick(input logic [1:0] req, input logic last);
    logic [1:0] r;
    r = 2'b00;
    case (req)
      2'b01:   r = 2'b10;
      2'b10:   r = 2'b11;
      2'b11:   r = (ARB_MODE == 1) ? {1'b1, ~last} : 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // The parked master never competes in normal arbitration.
  assign elig        = breq & ~(split_pending ? onehot(split_owner) : 2'b00);
  assign pick_r      = pick(elig, last_grant);
  // Park is dropped silently once the parked master stops requesting.
  assign park_cancel = split_pending && !breq[split_owner];
  assign resume      = split_pending && breq[split_owner] && !split;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      grant         <= 2'b00;
      msel          <= 1'b0;
      busy          <= 1'b0;
      split_owner   <= 1'b0;
      split_pending <= 1'b0;
      last_grant    <= 1'b1;
    end else begin
      case (state)
        IDLE, PARKED_IDLE: begin
          if (park_cancel) begin
            split_pending <= 1'b0;
          end
          if (resume) begin
            // Resume beats every other request and the arbitration mode.
            grant         <= onehot(split_owner);
            msel          <= split_owner;
            busy          <= 1'b1;
            last_grant    <= split_owner;
            split_pending <= 1'b0;
            state         <= BUSY;
          end else if (pick_r[1]) begin
            grant      <= onehot(pick_r[0]);
            msel       <= pick_r[0];
            busy       <= 1'b1;
            last_grant <= pick_r[0];
            state      <= BUSY;
          end else begin
            state <= (split_pending && !park_cancel) ? PARKED_IDLE : IDLE;
          end
        end

        BUSY: begin
          if (split && !split_pending) begin
            // Split wins even if the owner releases in the same cycle.
            grant         <= 2'b00;
            busy          <= 1'b0;
            split_pending <= 1'b1;
            split_owner   <= msel;
            state         <= PARKED_IDLE;
          end else begin
            if (park_cancel) begin
              split_pending <= 1'b0;
            end
            if (!breq[msel]) begin
              // Always fall to a no-grant state: this is the dead cycle.
              grant <= 2'b00;
              busy  <= 1'b0;
              state <= (split_pending && !park_cancel) ? PARKED_IDLE : IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
          grant <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_2m
//
// Drives one fixed-priority and one round-robin instance with the same inputs.
// A behavioural model (bus owner / parked master as plain integers, -1 = none)
// predicts both instances; a compare process checks every cycle. Directed
// scenarios pin the model with hand-computed literal expectations, followed
// by a long randomized run with occasional asynchronous resets.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_2m;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic [1:0] breq  = 2'b00;
  logic       split = 1'b0;

  logic [1:0] grant_f, grant_r;
  logic       msel_f, msel_r, busy_f, busy_r;
  logic       so_f, so_r, sp_f, sp_r;

  always #5 clk = ~clk;

  bus_arbiter_2m #(.ARB_MODE(0)) dut_f (
    .clk(clk), .rstn(rstn), .breq(breq), .split(split),
    .grant(grant_f), .msel(msel_f), .busy(busy_f),
    .split_owner(so_f), .split_pending(sp_f)
  );

  bus_arbiter_2m #(.ARB_MODE(1)) dut_r (
    .clk(clk), .rstn(rstn), .breq(breq), .split(split),
    .grant(grant_r), .msel(msel_r), .busy(busy_r),
    .split_owner(so_r), .split_pending(sp_r)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state, index 0 = fixed priority instance, 1 = round-robin instance.
  int m_owner[2]  = '{-1, -1};
  int m_parked[2] = '{-1, -1};
  int m_last[2]   = '{1, 1};
  int m_msel[2]   = '{0, 0};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_owner[m]  = -1;
      m_parked[m] = -1;
      m_last[m]   = 1;
      m_msel[m]   = 0;
    end
  endtask

  // Who owns the bus after this edge, given who owned it and who is parked.
  task automatic model_step(input int m, input logic [1:0] b, input logic s);
    int own, pk, nown, npk;
    bit want0, want1;
    own  = m_owner[m];
    pk   = m_parked[m];
    nown = -1;
    npk  = pk;
    if (pk >= 0 && !b[pk[0]]) npk = -1;
    if (own >= 0) begin
      if (s && pk < 0) npk = own;
      else if (b[own[0]]) nown = own;
    end else if (npk >= 0 && !s) begin
      nown = npk;
      npk  = -1;
    end else begin
      want0 = b[0] && (npk != 0);
      want1 = b[1] && (npk != 1);
      if (want0 && want1) nown = (m == 1) ? 1 - m_last[m] : 0;
      else if (want0)     nown = 0;
      else if (want1)     nown = 1;
    end
    if (nown >= 0) begin
      m_last[m] = nown;
      m_msel[m] = nown;
    end
    m_owner[m]  = nown;
    m_parked[m] = npk;
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      model_reset();
    end else begin
      model_step(0, breq, split);
      model_step(1, breq, split);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int m = 0; m < 2; m++) begin
        logic [1:0] g, eg;
        logic       ms, bz, sp, so;
        g  = (m == 1) ? grant_r : grant_f;
        ms = (m == 1) ? msel_r  : msel_f;
        bz = (m == 1) ? busy_r  : busy_f;
        sp = (m == 1) ? sp_r    : sp_f;
        so = (m == 1) ? so_r    : so_f;
        eg = (m_owner[m] < 0) ? 2'b00 : ((m_owner[m] == 0) ? 2'b01 : 2'b10);
        check($sformatf("cmp%0d_grant", m), 8'(g), 8'(eg));
        check($sformatf("cmp%0d_busy", m), 8'(bz), 8'(m_owner[m] >= 0));
        check($sformatf("cmp%0d_msel", m), 8'(ms), 8'(m_msel[m]));
        check($sformatf("cmp%0d_pending", m), 8'(sp), 8'(m_parked[m] >= 0));
        if (m_parked[m] >= 0)
          check($sformatf("cmp%0d_owner", m), 8'(so), 8'(m_parked[m]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs for the current cycle; returns one cycle later.
  task automatic cyc(input logic [1:0] b, input logic s);
    breq  = b;
    split = s;
    tick();
  endtask

  task automatic do_reset();
    breq  = 2'b00;
    split = 1'b0;
    rstn  = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  logic [1:0] rr_exp[16] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00,
                             2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};

  initial begin
    logic [1:0] b;
    logic       s;

    do_reset();
    cmp_en = 1'b1;
    check("rst_grant", 8'(grant_f), 8'h00);
    check("rst_busy", 8'(busy_f), 8'h00);
    check("rst_pending", 8'(sp_f), 8'h00);

    // Fixed priority: both request, master 0 first, then master 1 after a gap.
    cyc(2'b11, 1'b0);
    check("fix_c1_grant", 8'(grant_f), 8'h01);
    check("fix_c1_busy", 8'(busy_f), 8'h01);
    repeat (4) cyc(2'b11, 1'b0);
    check("fix_c5_grant", 8'(grant_f), 8'h01);
    cyc(2'b10, 1'b0);
    check("fix_c6_grant", 8'(grant_f), 8'h00);
    check("fix_c6_msel", 8'(msel_f), 8'h00);
    cyc(2'b10, 1'b0);
    check("fix_c7_grant", 8'(grant_f), 8'h02);
    check("fix_c7_msel", 8'(msel_f), 8'h01);
    cyc(2'b00, 1'b0);
    cyc(2'b00, 1'b0);

    // Round-robin: requests stay high, each owner releases after 3 cycles.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      if (c == 3 || c == 11)      b = 2'b10;
      else if (c == 7 || c == 15) b = 2'b01;
      else                        b = 2'b11;
      cyc(b, 1'b0);
      check($sformatf("rr_c%0d_grant", c + 1), 8'(grant_r), 8'(rr_exp[c]));
    end
    cyc(2'b00, 1'b0);

    // Split park, other master uses the bus, then resume ahead of a request.
    do_reset();
    cyc(2'b01, 1'b0);
    repeat (3) cyc(2'b01, 1'b0);
    cyc(2'b01, 1'b1);
    check("spl_c5_grant", 8'(grant_f), 8'h00);
    check("spl_c5_pending", 8'(sp_f), 8'h01);
    check("spl_c5_owner", 8'(so_f), 8'h00);
    cyc(2'b11, 1'b1);
    check("spl_c6_grant", 8'(grant_f), 8'h02);
    check("spl_c6_pending", 8'(sp_f), 8'h01);
    repeat (3) cyc(2'b11, 1'b1);
    cyc(2'b11, 1'b0);
    cyc(2'b11, 1'b0);
    cyc(2'b01, 1'b0);
    check("spl_c12_grant", 8'(grant_f), 8'h00);
    check("spl_c12_pending", 8'(sp_f), 8'h01);
    cyc(2'b11, 1'b0);
    check("spl_c13_grant_fix", 8'(grant_f), 8'h01);
    check("spl_c13_grant_rr", 8'(grant_r), 8'h01);
    check("spl_c13_pending", 8'(sp_f), 8'h00);
    cyc(2'b00, 1'b0);
    cyc(2'b00, 1'b0);

    // Parked master drops its request: park cancelled, no resume.
    do_reset();
    cyc(2'b01, 1'b0);
    cyc(2'b01, 1'b1);
    repeat (4) cyc(2'b01, 1'b1);
    check("cnl_c6_grant", 8'(grant_f), 8'h00);
    check("cnl_c6_pending", 8'(sp_f), 8'h01);
    cyc(2'b01, 1'b1);
    cyc(2'b00, 1'b1);
    check("cnl_c8_pending", 8'(sp_f), 8'h00);
    check("cnl_c8_grant", 8'(grant_f), 8'h00);
    cyc(2'b00, 1'b0);
    check("cnl_c9_grant", 8'(grant_f), 8'h00);

    // Asynchronous reset while master 1 is granted and master 0 is parked.
    do_reset();
    cyc(2'b01, 1'b0);
    cyc(2'b01, 1'b1);
    cyc(2'b11, 1'b1);
    check("ar_pre_grant", 8'(grant_f), 8'h02);
    check("ar_pre_pending", 8'(sp_f), 8'h01);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_grant_fix", 8'(grant_f), 8'h00);
    check("ar_grant_rr", 8'(grant_r), 8'h00);
    check("ar_busy", 8'(busy_f), 8'h00);
    check("ar_msel", 8'(msel_f), 8'h00);
    check("ar_pending", 8'(sp_f), 8'h00);
    check("ar_owner", 8'(so_f), 8'h00);
    breq  = 2'b10;
    split = 1'b0;
    @(posedge clk);
    #3;
    rstn = 1'b1;
    tick();
    check("ar_post_grant", 8'(grant_f), 8'h02);
    check("ar_post_pending", 8'(sp_f), 8'h00);
    cyc(2'b00, 1'b0);

    // Randomized run; requests are sticky so transactions last several cycles.
    for (int i = 0; i < 4000; i++) begin
      b = ($urandom_range(0, 9) < 7) ? breq : 2'($urandom_range(0, 3));
      s = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 399) == 0) begin
        #3;
        rstn = 1'b0;
        @(posedge clk);
        #2;
        rstn = 1'b1;
      end
      cyc(b, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
